// File: rtl/stack_pkg.sv
// Shared definitions for the recursion frame stack: frame field layout,
// default depth and push/pop operation decode.
package stack_pkg;

    localparam int unsigned N_MSB         = 7;
    localparam int unsigned N_LSB         = 4;
    localparam int unsigned K_MSB         = 3;
    localparam int unsigned K_LSB         = 0;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

    // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
    function automatic op_e decode_op(logic push, logic pop, logic empty);
        op_e op;
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Register array holding the frames below the top of the stack.
// One synchronous write port, one combinational read port, contents not reset.
module stack_regfile #(
    parameter int unsigned ENTRIES = 15,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned AW      = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [FRAME_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [FRAME_W-1:0] rdata
);

    logic [FRAME_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < ENTRIES) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/recursion_stack.sv
// LIFO frame stack for the recursive-evaluation datapath: registered top frame,
// depth/high-water tracking and sticky overflow/underflow flags.
module recursion_stack
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] push_data,
    output logic [FRAME_W-1:0] top_data,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   depth,
    output logic [CNT_W-1:0]   high_water,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned ENTRIES = DEPTH - 1;
    localparam int unsigned AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [FRAME_W-1:0] top_q, top_d;
    logic [CNT_W-1:0]   depth_q, depth_d;
    logic [CNT_W-1:0]   hw_q, hw_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               we;
    logic [AW-1:0]      waddr, raddr;
    logic [FRAME_W-1:0] rdata;
    op_e                op;

    assign empty = (depth_q == '0);
    assign full  = (depth_q == CNT_W'(DEPTH));

    // Old top spills to mem[depth-1]; frame under the top lives at mem[depth-2].
    assign waddr = AW'(depth_q - CNT_W'(1));
    assign raddr = AW'(depth_q - CNT_W'(2));
    assign op    = decode_op(push, pop, empty);

    stack_regfile #(
        .ENTRIES (ENTRIES),
        .FRAME_W (FRAME_W),
        .AW      (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (top_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        top_d   = top_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        if (clear) begin
            top_d   = '0;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we      = !empty;
                        top_d   = push_data;
                        depth_d = depth_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        top_d   = (depth_q == CNT_W'(1)) ? '0 : rdata;
                        depth_d = depth_q - CNT_W'(1);
                    end
                end
                OP_REPLACE: top_d = push_data;
                default: ;
            endcase
        end
        hw_d = clear ? '0 : ((depth_d > hw_q) ? depth_d : hw_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q   <= '0;
            depth_q <= '0;
            hw_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            depth_q <= depth_d;
            hw_q    <= hw_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top_data   = top_q;
    assign depth      = depth_q;
    assign high_water = hw_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_recursion_stack.sv
// Self-checking bench for recursion_stack: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_recursion_stack;

    localparam int DEPTH = 16;

    logic       clk, rst, clear, push, pop;
    logic [7:0] push_data, top_data;
    logic       empty, full, overflow, underflow;
    logic [4:0] depth, high_water;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [7:0] m_q[$];
    int         m_hw;
    logic       m_ovf, m_unf;

    recursion_stack #(.DEPTH(DEPTH), .FRAME_W(8), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .push_data  (push_data),
        .top_data   (top_data),
        .empty      (empty),
        .full       (full),
        .depth      (depth),
        .high_water (high_water),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_q.delete();
        m_hw  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic c, input logic [7:0] d);
        if (c) begin
            model_reset();
        end else if (p && q) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = d;
            else                m_q.push_back(d);
        end else if (p) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else                     m_q.push_back(d);
        end else if (q) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else                 void'(m_q.pop_back());
        end
        if (m_q.size() > m_hw) m_hw = m_q.size();
    endtask

    function automatic logic [7:0] m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 8'h00;
    endfunction

    // Drive at negedge, model follows the posedge, outputs sampled at the next negedge.
    task automatic cycle(input logic p, input logic q, input logic c, input logic [7:0] d);
        push = p; pop = q; clear = c; push_data = d;
        @(posedge clk);
        model_step(p, q, c, d);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = 8'h00;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({empty, full, depth, top_data, high_water, overflow, underflow} !==
            {1'b1, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: empty=%b full=%b depth=%0d top=%h hw=%0d ovf=%b unf=%b, need 1 0 0 00 0 0 0",
                     empty, full, depth, top_data, high_water, overflow, underflow);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] pushes [3] = '{8'h64, 8'h53, 8'h42};
        logic [7:0] tops   [3] = '{8'h53, 8'h64, 8'h00};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, pushes[i]);
            n_tests++;
            if (top_data !== pushes[i] || depth !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL push_%0d: top=%h depth=%0d, need top=%h depth=%0d",
                         i, top_data, depth, pushes[i], i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (top_data !== tops[i] || depth !== 5'(2 - i)) begin
                n_fail++;
                $display("FAIL pop_%0d: top=%h depth=%0d, need top=%h depth=%0d",
                         i, top_data, depth, tops[i], 2 - i);
            end
        end
        n_tests++;
        if (high_water !== 5'd3 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL push_pop_hw: hw=%0d empty=%b, need hw=3 empty=1", high_water, empty);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b0 || depth !== 5'd16 || top_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL fill: full=%b ovf=%b depth=%0d top=%h, need 1 0 16 0f",
                     full, overflow, depth, top_data);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b1 || depth !== 5'd16 || top_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL overflow: full=%b ovf=%b depth=%0d top=%h, need 1 1 16 0f",
                     full, overflow, depth, top_data);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'hBB);
        n_tests++;
        if (top_data !== 8'hBB || depth !== 5'd16 || underflow !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL replace_full: top=%h depth=%0d unf=%b ovf=%b, need bb 16 0 1",
                     top_data, depth, underflow, overflow);
        end
        // Unwind a few to check spilled frames come back in order.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (top_data !== 8'(14 - i)) begin
                n_fail++;
                $display("FAIL unwind_%0d: top=%h, need %h", i, top_data, 8'(14 - i));
            end
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_tests++;
        if (underflow !== 1'b1 || depth !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: unf=%b depth=%0d empty=%b, need 1 0 1", underflow, depth, empty);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h21);
        n_tests++;
        if (depth !== 5'd1 || top_data !== 8'h21 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL push_pop_empty: depth=%0d top=%h unf=%b, need 1 21 1",
                     depth, top_data, underflow);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        cycle(1'b1, 1'b0, 1'b1, 8'h77);
        n_tests++;
        if ({depth, top_data, high_water, overflow, underflow, empty} !==
            {5'd0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clear: depth=%0d top=%h hw=%0d ovf=%b unf=%b empty=%b, need 0 00 0 0 0 1",
                     depth, top_data, high_water, overflow, underflow, empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h50 + 8'(i));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({depth, top_data, high_water, empty} !== {5'd0, 8'h00, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: depth=%0d top=%h hw=%0d empty=%b, need 0 00 0 1",
                     depth, top_data, high_water, empty);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h11);
        n_tests++;
        if (depth !== 5'd1 || top_data !== 8'h11) begin
            n_fail++;
            $display("FAIL after_reset_push: depth=%0d top=%h, need 1 11", depth, top_data);
        end
    endtask

    task automatic test_random();
        logic p, q, c;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 60);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            cycle(p, q, c, 8'($urandom));
            n_tests++;
            if (top_data !== m_top() || depth !== 5'(m_q.size()) || high_water !== 5'(m_hw) ||
                overflow !== m_ovf || underflow !== m_unf ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL random_%0d: top=%h depth=%0d hw=%0d ovf=%b unf=%b e=%b f=%b, need %h %0d %0d %b %b",
                         i, top_data, depth, high_water, overflow, underflow, empty, full,
                         m_top(), m_q.size(), m_hw, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
